// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared pipeline definitions: control packing, ALUOp codes, register index width
package pipe_defs;

  localparam int CTRL_W = 9;
  localparam int REG_AW = 5;

  // Bit positions in the packed control word {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst,Branch}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 2;
  localparam int CTRL_REGDST   = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard term between ID and the load sitting in EX
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  output logic              hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs_i & (id_rs_i == ex_rt_i);
  assign rt_match = id_uses_rt_i & (id_rt_i == ex_rt_i);

  // A load into $0 never produces a value worth waiting for
  assign hazard_o = ex_mem_read_i & (ex_rt_i != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall; optional bubble counter under ID_EX_BUBBLE_CNT_EN
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [pipe_defs::CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0]           rs_data_i,
  input  logic [DATA_W-1:0]           rt_data_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [REG_AW-1:0]           rs_i,
  input  logic [REG_AW-1:0]           rt_i,
  input  logic [REG_AW-1:0]           rd_i,
  input  logic                        uses_rs_i,
  input  logic                        uses_rt_i,
  output logic [pipe_defs::CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0]           rs_data_o,
  output logic [DATA_W-1:0]           rt_data_o,
  output logic [DATA_W-1:0]           imm_o,
  output logic [REG_AW-1:0]           rs_o,
  output logic [REG_AW-1:0]           rt_o,
  output logic [REG_AW-1:0]           rd_o,
  output logic                        hazard_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]                 bubble_cnt_o
`endif
);

  import pipe_defs::*;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              raw_hazard;
  logic              bubble_load;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i       (rt_q),
    .id_rs_i       (rs_i),
    .id_rt_i       (rt_i),
    .id_uses_rs_i  (uses_rs_i),
    .id_uses_rt_i  (uses_rt_i),
    .hazard_o      (raw_hazard)
  );

  // A flush already discards the ID instruction, so there is nothing to stall for
  assign hazard_o    = raw_hazard & ~flush_i;
  assign bubble_load = ~stall_i & (flush_i | raw_hazard);

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (stall_i) begin
      ctrl_d = ctrl_q;
    end else if (flush_i) begin
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else begin
      // On a hazard the operands still load; only the zeroed control makes it a bubble
      ctrl_d    = raw_hazard ? '0 : ctrl_i;
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      rs_d      = rs_i;
      rt_d      = rt_i;
      rd_d      = rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign rs_data_o = rs_data_q;
  assign rt_data_o = rt_data_q;
  assign imm_o     = imm_q;
  assign rs_o      = rs_q;
  assign rt_o      = rt_q;
  assign rd_o      = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  assign bubble_cnt_d = bubble_load ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_load;
`endif

endmodule
